// File: rtl/dsp_mac_pkg.sv
// Shared OPMODE field positions, post-adder select encodings and the
// per-sample post-adder control word carried down the pipeline.
package dsp_mac_pkg;

  localparam int unsigned OP_POST_SUB = 7;
  localparam int unsigned OP_PRE_SUB  = 6;
  localparam int unsigned OP_CIN      = 5;
  localparam int unsigned OP_BSEL     = 4;
  localparam int unsigned OP_Z_LSB    = 2;
  localparam int unsigned OP_X_LSB    = 0;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  // Only the OPMODE fields still needed after the pre-adder stage
  typedef struct packed {
    logic       sub;
    logic       cin;
    logic [1:0] zsel;
    logic [1:0] xsel;
  } post_op_t;

  function automatic post_op_t post_op(input logic [7:0] op);
    post_op_t r;
    r.sub  = op[OP_POST_SUB];
    r.cin  = op[OP_CIN];
    r.zsel = op[OP_Z_LSB +: 2];
    r.xsel = op[OP_X_LSB +: 2];
    return r;
  endfunction

endpackage

// File: rtl/dsp_post_adder.sv
// Combinational post-adder: Z +/- (X + CIN) with carry/borrow out and
// optional clamping to all-ones (carry) or zero (borrow).
module dsp_post_adder #(
  parameter int unsigned W      = 48,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] z,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] res_c,
  output logic         carry_c,
  output logic         ovf_c
);

  logic [W:0] raw;

  // Compute at W+1 bits so the top bit is the carry or the borrow
  always_comb begin
    raw = '0;
    if (sub) raw = {1'b0, z} - ({1'b0, x} + (W+1)'(cin));
    else     raw = {1'b0, z} + {1'b0, x} + (W+1)'(cin);
    carry_c = raw[W];
    ovf_c   = SAT_EN && raw[W];
    res_c   = raw[W-1:0];
    if (ovf_c) res_c = sub ? '0 : '1;
  end

endmodule

// File: rtl/dsp_mac_slice.sv
// Four-stage pre-add / multiply / post-add MAC slice with per-sample valid,
// pipelined OPMODE, frame-based accumulation and optional saturation.
module dsp_mac_slice
  import dsp_mac_pkg::*;
#(
  parameter int unsigned A_WIDTH = 18,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned D_WIDTH = 18,
  parameter int unsigned P_WIDTH = 48,
  parameter int unsigned ACC_LEN = 0,
  parameter int unsigned SAT_EN  = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic                       IN_VALID,
  input  logic [7:0]                 OPMODE,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  input  logic [D_WIDTH-1:0]         D,
  input  logic [P_WIDTH-1:0]         C,
  input  logic [P_WIDTH-1:0]         PCIN,
  output logic [B_WIDTH-1:0]         BCOUT,
  output logic [A_WIDTH+B_WIDTH-1:0] M,
  output logic [P_WIDTH-1:0]         P,
  output logic [P_WIDTH-1:0]         PCOUT,
  output logic                       CARRYOUT,
  output logic                       OUT_VALID,
  output logic                       OUT_LAST,
  output logic                       OVF
);

  localparam int unsigned M_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int unsigned CNT_WIDTH = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  logic                 v1, v2, v3;
  logic [7:0]           op1;
  post_op_t             op2, op3;
  logic [A_WIDTH-1:0]   a1, a2, a3;
  logic [B_WIDTH-1:0]   b1, b3;
  logic [D_WIDTH-1:0]   d1, d2, d3;
  logic [P_WIDTH-1:0]   c1, c2, c3, pcin1, pcin2, pcin3;
  logic [B_WIDTH-1:0]   pre_c;
  logic [P_WIDTH-1:0]   x_c, z_c, res_c;
  logic                 carry_c, ovf_c, frame_start_c, last_c;
  logic [CNT_WIDTH-1:0] cnt;

  // S1: capture operands and OPMODE of each valid sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1 <= 1'b0; op1 <= '0; a1 <= '0; b1 <= '0; d1 <= '0; c1 <= '0; pcin1 <= '0;
    end else if (CE) begin
      v1 <= IN_VALID;
      if (IN_VALID) begin
        op1 <= OPMODE; a1 <= A; b1 <= B; d1 <= D; c1 <= C; pcin1 <= PCIN;
      end
    end
  end

  // Pre-adder wraps modulo 2^B_WIDTH
  always_comb begin
    pre_c = b1;
    if (op1[OP_BSEL]) begin
      if (op1[OP_PRE_SUB]) pre_c = B_WIDTH'(d1) - b1;
      else                 pre_c = B_WIDTH'(d1) + b1;
    end
  end

  // S2: register BCOUT and carry the sample's remaining fields
  always_ff @(posedge CLK) begin
    if (RST) begin
      v2 <= 1'b0; op2 <= '0; a2 <= '0; d2 <= '0; c2 <= '0; pcin2 <= '0; BCOUT <= '0;
    end else if (CE) begin
      v2 <= v1;
      if (v1) begin
        op2 <= post_op(op1); a2 <= a1; d2 <= d1; c2 <= c1; pcin2 <= pcin1; BCOUT <= pre_c;
      end
    end
  end

  // S3: unsigned multiply; keep A/BCOUT/D copies for the DAB concat
  always_ff @(posedge CLK) begin
    if (RST) begin
      v3 <= 1'b0; op3 <= '0; a3 <= '0; b3 <= '0; d3 <= '0; c3 <= '0; pcin3 <= '0; M <= '0;
    end else if (CE) begin
      v3 <= v2;
      if (v2) begin
        op3 <= op2; a3 <= a2; b3 <= BCOUT; d3 <= d2; c3 <= c2; pcin3 <= pcin2;
        M   <= M_WIDTH'(a2) * M_WIDTH'(BCOUT);
      end
    end
  end

  assign frame_start_c = (ACC_LEN != 0) && (cnt == '0);
  assign last_c        = (ACC_LEN != 0) && (cnt == CNT_WIDTH'(ACC_LEN - 1));

  // X/Z operand selection; Z=P starts a fresh frame from zero
  always_comb begin
    x_c = '0;
    z_c = '0;
    case (op3.xsel)
      X_M:     x_c = P_WIDTH'(M);
      X_P:     x_c = P;
      X_DAB:   x_c = P_WIDTH'({d3, a3, b3});
      default: x_c = '0;
    endcase
    case (op3.zsel)
      Z_PCIN:  z_c = pcin3;
      Z_P:     z_c = frame_start_c ? '0 : P;
      Z_C:     z_c = c3;
      default: z_c = '0;
    endcase
  end

  dsp_post_adder #(
    .W      (P_WIDTH),
    .SAT_EN (SAT_EN != 0)
  ) u_post_adder (
    .x       (x_c),
    .z       (z_c),
    .cin     (op3.cin),
    .sub     (op3.sub),
    .res_c   (res_c),
    .carry_c (carry_c),
    .ovf_c   (ovf_c)
  );

  // S4: result, flags and frame counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      P <= '0; CARRYOUT <= 1'b0; OUT_VALID <= 1'b0; OUT_LAST <= 1'b0; OVF <= 1'b0; cnt <= '0;
    end else if (CE) begin
      OUT_VALID <= v3;
      OUT_LAST  <= v3 && last_c;
      if (v3) begin
        P        <= res_c;
        CARRYOUT <= carry_c;
        if (ovf_c) OVF <= 1'b1;
        if (ACC_LEN != 0) cnt <= last_c ? '0 : cnt + 1'b1;
      end
    end
  end

  assign PCOUT = P;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Bench for dsp_mac_slice (ACC_LEN=4, SAT_EN=1): a queue-based sample model
// compared every cycle, plus hand-computed directed expectations.
module tb_dsp_mac_slice;

  localparam int unsigned AW = 18, BW = 18, DW = 18, PW = 48;

  logic          CLK, RST, CE, IN_VALID;
  logic [7:0]    OPMODE;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic [DW-1:0] D;
  logic [PW-1:0] C, PCIN;
  logic [BW-1:0] BCOUT;
  logic [AW+BW-1:0] M;
  logic [PW-1:0] P, PCOUT;
  logic          CARRYOUT, OUT_VALID, OUT_LAST, OVF;

  int checks = 0;
  int errors = 0;

  dsp_mac_slice #(
    .A_WIDTH(AW), .B_WIDTH(BW), .D_WIDTH(DW), .P_WIDTH(PW), .ACC_LEN(4), .SAT_EN(1)
  ) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .OPMODE(OPMODE),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
    .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT),
    .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .OVF(OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0]  op;
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    int          age;
  } smp_t;

  smp_t        q[$];
  smp_t        s;
  bit          started = 0;
  logic [17:0] m_bc;
  logic [35:0] m_m;
  logic [47:0] m_p;
  logic        m_co, m_ov, m_last, m_ovf;
  int          m_cnt;

  function automatic logic [17:0] pre_f(input smp_t t);
    logic [17:0] r;
    if (t.op[4]) r = t.op[6] ? t.d - t.b : t.d + t.b;
    else         r = t.b;
    return r;
  endfunction

  function automatic logic [35:0] mul_f(input smp_t t);
    logic [35:0] aa, bb;
    aa = {18'b0, t.a};
    bb = {18'b0, pre_f(t)};
    return aa * bb;
  endfunction

  always @(posedge CLK) begin
    logic [47:0] xx, zz, pp;
    logic [48:0] r;
    logic [53:0] dab;
    if (RST) begin
      q.delete();
      m_bc = '0; m_m = '0; m_p = '0; m_co = 0; m_ov = 0; m_last = 0; m_ovf = 0; m_cnt = 0;
      started = 1;
    end else if (CE) begin
      for (int i = 0; i < q.size(); i++) q[i].age++;
      if (IN_VALID) begin
        s.op = OPMODE; s.a = A; s.b = B; s.d = D; s.c = C; s.pcin = PCIN; s.age = 1;
        q.push_back(s);
      end
      m_ov = 0; m_last = 0;
      if (q.size() > 0 && q[0].age == 4) begin
        s = q.pop_front();
        dab = {s.d, s.a, pre_f(s)};
        case (s.op[1:0])
          2'd0: xx = '0;
          2'd1: xx = {12'b0, mul_f(s)};
          2'd2: xx = m_p;
          default: xx = dab[47:0];
        endcase
        case (s.op[3:2])
          2'd0: zz = '0;
          2'd1: zz = s.pcin;
          2'd2: zz = (m_cnt == 0) ? 48'd0 : m_p;
          default: zz = s.c;
        endcase
        if (s.op[7]) r = {1'b0, zz} - ({1'b0, xx} + {48'b0, s.op[5]});
        else         r = {1'b0, zz} + {1'b0, xx} + {48'b0, s.op[5]};
        m_co = r[48];
        pp = r[47:0];
        if (r[48]) begin
          m_ovf = 1;
          pp = s.op[7] ? 48'd0 : {48{1'b1}};
        end
        m_p = pp;
        m_ov = 1;
        m_last = (m_cnt == 3);
        m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
      end
      foreach (q[i]) begin
        if (q[i].age == 2) m_bc = pre_f(q[i]);
        if (q[i].age == 3) m_m = mul_f(q[i]);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge CLK) begin
    if (started) begin
      chk("m_BCOUT", 64'(BCOUT), 64'(m_bc));
      chk("m_M", 64'(M), 64'(m_m));
      chk("m_P", 64'(P), 64'(m_p));
      chk("m_PCOUT", 64'(PCOUT), 64'(m_p));
      chk("m_CARRYOUT", 64'(CARRYOUT), 64'(m_co));
      chk("m_OUT_VALID", 64'(OUT_VALID), 64'(m_ov));
      chk("m_OUT_LAST", 64'(OUT_LAST), 64'(m_last));
      chk("m_OVF", 64'(OVF), 64'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [7:0] op, input logic [17:0] a, b, d,
                      input logic [47:0] c, pcin);
    IN_VALID = v; OPMODE = op; A = a; B = b; D = d; C = c; PCIN = pcin;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
         48'({$urandom, $urandom}), 48'({$urandom, $urandom}));
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) step(1'b1, 8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
                    48'({$urandom, $urandom}), 48'({$urandom, $urandom}));
    RST = 1'b0;
  endtask

  localparam logic [47:0] ONES = {48{1'b1}};

  initial begin
    RST = 1'b1; CE = 1'b1; IN_VALID = 1'b0; OPMODE = '0;
    A = '0; B = '0; D = '0; C = '0; PCIN = '0;

    // Reset with random inputs
    do_reset(2);
    chk("rst_BCOUT", 64'(BCOUT), 0);
    chk("rst_M", 64'(M), 0);
    chk("rst_P", 64'(P), 0);
    chk("rst_PCOUT", 64'(PCOUT), 0);
    chk("rst_flags", {60'b0, CARRYOUT, OUT_VALID, OUT_LAST, OVF}, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("rst_release_OUT_VALID", 64'(OUT_VALID), 0);
    end

    // Single sample 0x3D: BCOUT=8, M=16, P=10+16+1=27
    step(1'b1, 8'h3D, 18'd2, 18'd3, 18'd5, 48'd10, 48'd0);
    idle(); chk("single_BCOUT", 64'(BCOUT), 8);
    idle(); chk("single_M", 64'(M), 16);
    idle(); chk("single_P", 64'(P), 27);
    chk("single_CARRYOUT", 64'(CARRYOUT), 0);
    chk("single_OUT_VALID", 64'(OUT_VALID), 1);

    // Back-to-back: 27, then 100 - (2*2) = 96
    do_reset(1);
    step(1'b1, 8'h3D, 18'd2, 18'd3, 18'd5, 48'd10, 48'd0);
    step(1'b1, 8'hDD, 18'd2, 18'd3, 18'd5, 48'd100, 48'd100);
    idle(); idle();
    chk("b2b_P0", 64'(P), 27); chk("b2b_V0", 64'(OUT_VALID), 1);
    idle();
    chk("b2b_P1", 64'(P), 96); chk("b2b_V1", 64'(OUT_VALID), 1);
    idle();
    chk("b2b_V2", 64'(OUT_VALID), 0);

    // Accumulation frame of 4: 12,24,36,48(last),12
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      if (i < 5) step(1'b1, 8'h09, 18'd3, 18'd4, 18'd0, 48'd0, 48'd0);
      else       idle();
      case (i)
        3: chk("acc_P0", 64'(P), 12);
        4: chk("acc_P1", 64'(P), 24);
        5: chk("acc_P2", 64'(P), 36);
        6: begin chk("acc_P3", 64'(P), 48); chk("acc_LAST3", 64'(OUT_LAST), 1); end
        7: begin chk("acc_P4", 64'(P), 12); chk("acc_LAST4", 64'(OUT_LAST), 0); end
        default: ;
      endcase
    end

    // Saturation: carry clamps to all-ones, borrow clamps to zero
    do_reset(1);
    step(1'b1, 8'h0F, 18'd1, 18'd0, 18'd0, ONES, 48'd0);
    step(1'b1, 8'hD5, 18'd2, 18'd3, 18'd5, 48'd0, 48'd0);
    idle(); idle();
    chk("sat_P_ones", 64'(P), 64'(ONES));
    chk("sat_CARRY", 64'(CARRYOUT), 1);
    chk("sat_OVF", 64'(OVF), 1);
    idle();
    chk("sat_P_zero", 64'(P), 0);
    chk("sat_BORROW", 64'(CARRYOUT), 1);
    idle(); idle();
    chk("sat_OVF_sticky", 64'(OVF), 1);

    // CE low for 3 cycles mid-stream
    do_reset(1);
    step(1'b1, 8'h3D, 18'd2, 18'd3, 18'd5, 48'd10, 48'd0);
    step(1'b1, 8'h3D, 18'd4, 18'd1, 18'd1, 48'd10, 48'd0);
    CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h3D, 18'd7, 18'd7, 18'd7, 48'd7, 48'd7);
      chk("ce_hold_BCOUT", 64'(BCOUT), 8);
      chk("ce_hold_OUT_VALID", 64'(OUT_VALID), 0);
    end
    CE = 1'b1;
    idle(); chk("ce_resume_M", 64'(M), 16); chk("ce_resume_BCOUT", 64'(BCOUT), 2);
    idle(); chk("ce_resume_P0", 64'(P), 27);
    idle(); chk("ce_resume_P1", 64'(P), 19);

    // RST for one cycle mid-stream, then a sample on the first cycle after
    do_reset(1);
    step(1'b1, 8'h3D, 18'd2, 18'd3, 18'd5, 48'd10, 48'd0);
    step(1'b1, 8'h3D, 18'd4, 18'd1, 18'd1, 48'd10, 48'd0);
    do_reset(1);
    step(1'b1, 8'h3D, 18'd2, 18'd3, 18'd5, 48'd10, 48'd0);
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("midrst_OUT_VALID", 64'(OUT_VALID), 0);
    end
    idle();
    chk("midrst_new_P", 64'(P), 27);
    chk("midrst_new_VALID", 64'(OUT_VALID), 1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("midrst_tail_VALID", 64'(OUT_VALID), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
